mem_access_unit: RTL and testbench
==================================

# mem_access_unit

- Load/store front-end between the execute stage and the word-addressed data memory.
- Accepts byte-addressed load/store requests of byte, halfword or word size, and drives the memory's word address, write data and write enable.
- Performs sub-word stores as a two-access read-modify-write, and aligns and sign/zero-extends load data.
- Returns one response pulse per request, with an error flag for illegal accesses.

## Interface

Parameters:
- WADDR_W, default 10: width of the memory word address; 10 gives 1024 words.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: a request is presented; it is accepted when req_valid and req_ready are both 1 at a rising edge.
- req_ready, output, 1: the unit is idle and can accept a request.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed, input, 1: for loads, 1 = sign-extend, 0 = zero-extend.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned.
- resp_valid, output, 1: one-cycle completion pulse.
- resp_rdata, output, 32: extended load data; 0 for stores and errors.
- resp_err, output, 1: the request was rejected; valid with resp_valid.
- mem_addr, output, WADDR_W: word address, taken from req_addr[WADDR_W+1:2].
- mem_wdata, output, 32: write word to memory.
- mem_we, output, 1: memory write enable.
- mem_rdata, input, 32: combinational read data from memory at mem_addr.

## Operation

- Byte lanes are little-endian: offset 0 is bits [7:0] and offset 3 is bits [31:24].
- States are IDLE, LOAD, WSTORE, RMW_RD, RMW_WR.
- On acceptance in IDLE, the unit latches req_we, req_size, req_signed, the word address, the offset req_addr[1:0] and req_wdata.

Transitions out of IDLE, in priority order:
- Size 11, or misaligned with the check enabled (see Configuration): stay in IDLE; resp_valid=1 and resp_err=1 on the next cycle; no memory access.
- Load: go to LOAD.
- Word store: go to WSTORE.
- Byte or half store: go to RMW_RD.

Per-state behaviour:
- LOAD: select the lane(s) of mem_rdata by offset, extend to 32 bits per req_signed, register into resp_rdata, then return to IDLE.
- WSTORE: mem_we=1 and mem_wdata=latched data; return to IDLE.
- RMW_RD: latch mem_rdata into a merge register, then go to RMW_WR.
- RMW_WR: mem_we=1; mem_wdata is the merge register with the target lane(s) replaced by the low 8 or 16 bits of the store data; return to IDLE.
- Every transition back to IDLE registers resp_valid=1 for exactly one cycle, with resp_err=0.

Output rules:
- mem_we is decoded from the state only. It is never high in IDLE, LOAD or RMW_RD.
- mem_addr holds the latched word address in all states.
- resp_rdata holds its value until the next response.

## Timing

Reset values (all outputs):
- State is IDLE; req_ready=1.
- resp_valid=0, resp_err=0, resp_rdata=0.
- mem_we=0, mem_addr=0, mem_wdata=0.

Latency from the acceptance edge T:
- Load: resp_valid at T+2.
- Word store: memory written at the T+2 edge; resp_valid at T+2.
- Sub-word store: read during T+1..T+2; write at the T+3 edge; resp_valid at T+3.
- Error: resp_valid at T+1.

Throughput and boundary conditions:
- req_ready=1 only in IDLE. A new request can be accepted in the same cycle that resp_valid is high, so back-to-back loads complete every 2 cycles.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- Reset asserted mid-operation aborts the request immediately: mem_we drops asynchronously, no partial write, no response.
- A sub-word store replaces only its addressed lane(s); all other bytes keep their pre-store value.
- Word address wraps modulo 2^WADDR_W; req_addr bits above WADDR_W+1 are ignored.

## Configuration

Macro: MAU_MISALIGN_TRAP_EN.
- Defined: half with req_addr[0]=1, or word with req_addr[1:0]≠00, is rejected with resp_err=1 and no memory access.
- Undefined: no alignment check and no error for misalignment. A half uses only req_addr[1] (lanes 0-1 or 2-3); a word ignores req_addr[1:0].
- Size 11 is rejected in both builds.

## Test plan

- Word store then load: store 0xDEADBEEF at byte 0x10, then load the word at 0x10 → mem_we high for 1 cycle with mem_addr=4; resp_rdata=0xDEADBEEF at T+2.
- Sub-word RMW: with memory word 4 = 0x11223344, store byte 0xAA at 0x12, then load the word → 0x11AA3344; only RMW_WR raises mem_we.
- Load extension: with word = 0x80FF7F01, signed byte at offset 2 → 0xFFFFFFFF; unsigned half at offset 2 → 0x000080FF; signed half at offset 0 → 0x00007F01.
- Errors: size=11 → resp_err at T+1 with no mem_we. With MAU_MISALIGN_TRAP_EN, word load at 0x13 → resp_err=1. Without it, the same load returns word 4.
- Reset mid-RMW: deassert rst_n during RMW_WR → mem_we goes to 0 at once, memory is unchanged, outputs are at reset values, and req_ready=1.
- Handshake: hold req_valid across the busy cycles → exactly one acceptance per request, back-to-back loads complete every 2 cycles, and no response is lost.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-addressed data memory: byte/half/word accesses,
// read-modify-write sub-word stores. Optional alignment trap: define MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int WADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WSTORE,
    RMW_RD,
    RMW_WR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        merge_q, merge_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;

  logic               misaligned;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;
  logic [31:0]        load_data;
  logic [3:0]         lane_en;
  logic [31:0]        merged;

`ifdef MAU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Address bits above the memory window are intentionally dropped (wrap-around).
  generate
    if (WADDR_W < 30) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[31:WADDR_W+2];
    end
  endgenerate

  // Load alignment: a half only looks at offset bit 1, so it never straddles lanes.
  always_comb begin
    load_byte = mem_rdata[{off_q, 3'b000} +: 8];
    load_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{sgn_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{sgn_q & load_half[15]}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Store merge: selected lanes take store data, the rest keep the word read in RMW_RD.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] src;
      assign src = (LANE[0] && (size_q == SZ_HALF)) ? wdata_q[15:8] : wdata_q[7:0];
      assign lane_en[gi] = (size_q == SZ_BYTE) ? (off_q == LANE) : (off_q[1] == LANE[1]);
      assign merged[8*gi +: 8] = lane_en[gi] ? src : merge_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr[WADDR_W+1:2];
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if ((req_size == SZ_RSVD) || misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size == SZ_WORD) begin
            state_d = WSTORE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD, WSTORE, RMW_WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? 32'h0 : load_data;
      end
      RMW_RD: begin
        merge_d = mem_rdata;
        state_d = RMW_WR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Write enable comes straight from state so an async reset kills it immediately.
  assign mem_we    = (state_q == WSTORE) || (state_q == RMW_WR);
  assign mem_addr  = addr_q;
  assign req_ready = (state_q == IDLE);

  always_comb begin
    case (state_q)
      WSTORE:  mem_wdata = wdata_q;
      RMW_WR:  mem_wdata = merged;
      default: mem_wdata = 32'h0;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array memory model, expected
// responses queued at acceptance and checked when resp_valid fires.
module tb_mem_access_unit;
  localparam int WADDR_W = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_signed;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic [WADDR_W-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_we;
  logic [31:0]        mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.WADDR_W(WADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, write on rising edge.
  logic [31:0] mem [0:1023];
  logic        mem_clear;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory kept as bytes, little-endian.
  logic [7:0] sh [0:4095];

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) wr_count++;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got err=%0d rdata=%08h, required no response", resp_err, resp_rdata);
      end else begin
        mon_e = q.pop_front();
        if (resp_err !== mon_e.err || resp_rdata !== mon_e.rdata || (cyc - mon_e.acc) != mon_e.lat) begin
          errors++;
          $display("FAIL resp: got err=%0d rdata=%08h lat=%0d, required err=%0d rdata=%08h lat=%0d",
                   resp_err, resp_rdata, cyc - mon_e.acc, mon_e.err, mon_e.rdata, mon_e.lat);
        end else begin
          $display("resp ok: err=%0d rdata=%08h lat=%0d", resp_err, resp_rdata, mon_e.lat);
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic s);
    logic [11:0] b;
    logic [15:0] h;
    logic [31:0] v;
    v = 32'h0;
    case (sz)
      2'b00: begin
        b = a[11:0];
        v = {24'h0, sh[b]};
        if (s && sh[b][7]) v[31:8] = 24'hFFFFFF;
      end
      2'b01: begin
        b = {a[11:1], 1'b0};
        h = {sh[b + 12'd1], sh[b]};
        v = {16'h0, h};
        if (s && h[15]) v[31:16] = 16'hFFFF;
      end
      default: begin
        b = {a[11:2], 2'b00};
        v = {sh[b + 12'd3], sh[b + 12'd2], sh[b + 12'd1], sh[b]};
      end
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [11:0] b;
    case (sz)
      2'b00: sh[a[11:0]] = d[7:0];
      2'b01: begin
        b = {a[11:1], 1'b0};
        sh[b] = d[7:0];
        sh[b + 12'd1] = d[15:8];
      end
      default: begin
        b = {a[11:2], 2'b00};
        for (int k = 0; k < 4; k++) sh[b + 12'(k)] = d[8*k +: 8];
      end
    endcase
  endtask

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Present a request, hold it until accepted, queue the expected response.
  task automatic op_exp(input logic we, input logic [1:0] sz, input logic s, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = s; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0d after %0d cycles, required 1", req_ready, n);
    end else begin
      lat = exp_err ? 1 : (!we ? 2 : (sz == 2'b10 ? 2 : 3));
      q.push_back('{err: exp_err, rdata: exp_rdata, lat: lat, acc: cyc});
      last_acc = cyc;
      $display("req: we=%0d size=%0d signed=%0d addr=%08h wdata=%08h", we, sz, s, a, d);
      if (we && !exp_err) model_store(a, sz, d);
      @(posedge clk);
    end
  endtask

  task automatic op(input logic we, input logic [1:0] sz, input logic s, input logic [31:0] a,
                    input logic [31:0] d);
    logic e;
    e = is_err(sz, a);
    op_exp(we, sz, s, a, d, e, (e || we) ? 32'h0 : model_load(a, sz, s));
  endtask

  task automatic drain(input string name);
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n = 0;
    while ((q.size() != 0 || !req_ready) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0 || !req_ready) begin
      errors++;
      $display("FAIL drain_%s: pending=%0d req_ready=%0d, required 0 and 1", name, q.size(), req_ready);
      q.delete();
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 7;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d required 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0d required 0", resp_valid); end
    if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %0d required 0", resp_err); end
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %08h required 0", resp_rdata); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0d required 0", mem_we); end
    if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %0h required 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %08h required 0", mem_wdata); end
  endtask

  task automatic test_word_store_load;
    int wr0;
    drain("pre_word");
    wr0 = wr_count;
    op_exp(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    @(negedge clk);
    checks += 3;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL wstore_we: got %0d required 1", mem_we); end
    if (mem_addr !== 10'd4) begin errors++; $display("FAIL wstore_addr: got %0d required 4", mem_addr); end
    if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wstore_wdata: got %08h required deadbeef", mem_wdata); end
    drain("wstore");
    checks++;
    if (wr_count - wr0 != 1) begin errors++; $display("FAIL wstore_pulses: got %0d required 1", wr_count - wr0); end
    op_exp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    drain("wload");
    repeat (2) @(negedge clk);
    checks++;
    if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %08h required deadbeef", resp_rdata); end
  endtask

  task automatic test_rmw;
    int wr0;
    op_exp(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0);
    drain("rmw_pre");
    wr0 = wr_count;
    op_exp(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rmw_rd_we: got %0d required 0", mem_we); end
    @(negedge clk);
    checks += 2;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rmw_wr_we: got %0d required 1", mem_we); end
    if (mem_wdata !== 32'h11AA3344) begin errors++; $display("FAIL rmw_wdata: got %08h required 11aa3344", mem_wdata); end
    drain("rmw");
    checks++;
    if (wr_count - wr0 != 1) begin errors++; $display("FAIL rmw_pulses: got %0d required 1", wr_count - wr0); end
    op_exp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11AA3344);
    op_exp(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF, 1'b0, 32'h0);
    op_exp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11AABEEF);
    op_exp(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h000011AA);
    drain("rmw_half");
  endtask

  task automatic test_load_ext;
    op_exp(1'b1, 2'b10, 1'b0, 32'h14, 32'h80FF7F01, 1'b0, 32'h0);
    op_exp(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, 1'b0, 32'hFFFFFFFF);
    op_exp(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, 32'h000080FF);
    op_exp(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1'b0, 32'h00007F01);
    op_exp(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 1'b0, 32'hFFFFFF80);
    op_exp(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 1'b0, 32'h0000007F);
    op_exp(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0, 32'hFFFF80FF);
    drain("ext");
  endtask

  task automatic test_errors;
    int wr0;
    wr0 = wr_count;
    op_exp(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);
    op_exp(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 1'b1, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
    op_exp(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    op_exp(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    op_exp(1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFECAFE, 1'b1, 32'h0);
`else
    op_exp(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, 32'h11AABEEF);
    op_exp(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b0, 32'h000011AA);
`endif
    drain("err");
    checks++;
    if (wr_count != wr0) begin errors++; $display("FAIL err_no_write: got %0d writes required 0", wr_count - wr0); end
  endtask

  task automatic test_reset_mid_rmw;
    op_exp(1'b1, 2'b10, 1'b0, 32'h18, 32'h55667788, 1'b0, 32'h0);
    drain("rst_pre");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h19; req_wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: mem_we=%0d required 1", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    checks += 7;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %0d required 0", mem_we); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0d required 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0d required 0", resp_valid); end
    if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %0d required 0", resp_err); end
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %08h required 0", resp_rdata); end
    if (mem_addr !== '0) begin errors++; $display("FAIL rst_mid_addr: got %0h required 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid_wdata: got %08h required 0", mem_wdata); end
    @(negedge clk);
    checks++;
    if (mem[6] !== 32'h55667788) begin errors++; $display("FAIL rst_mid_mem: got %08h required 55667788", mem[6]); end
    rst_n = 1'b1;
    op_exp(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b0, 32'h55667788);
    drain("rst_post");
  endtask

  task automatic test_back_to_back;
    int acc [4];
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 2'b10, 1'b0, 32'h10 + 32'(4 * (i % 3)), 32'h0);
      acc[i] = last_acc;
    end
    op(1'b1, 2'b00, 1'b0, 32'h1B, 32'h0000005A);
    op(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    drain("b2b");
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 2) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles required 2", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 15)) << 12) | (32'h100 + 32'($urandom_range(0, 63)));
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    drain("rand");
    for (int w = 64; w < 80; w++) begin
      checks++;
      if (mem[w] !== {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]}) begin
        errors++;
        $display("FAIL rand_mem%0d: got %08h required %08h", w, mem[w], {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_clear = 1'b1;
    for (int i = 0; i < 4096; i++) sh[i] = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_word_store_load();
    test_rmw();
    test_load_ext();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
